// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dec7seg.sv
// BCD to active-low 7-segment decoder, output order {g,f,e,d,c,b,a}.
module dec7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan of a common-anode 7-segment display with guard blanking,
// frame-aligned data update and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_digits,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg,
  output logic                    dp_n
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(max3(REFRESH_DIV, GUARD, 1) + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);

  scan_state_t             state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    pend_reg;
  logic [4*NUM_DIGITS-1:0] pend_digits_reg, act_digits_reg;
  logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
  logic [NUM_DIGITS-1:0]   an_n_reg, an_n_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_n_reg, dp_n_next;

  logic [3:0]              act_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_seg;
  logic                    frame_end;

  // zero_above[i]: digit i and every more significant digit are zero
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign act_nib[gi]    = act_digits_reg[4*gi +: 4];
    assign zero_above[gi] = (act_digits_reg[4*NUM_DIGITS-1:4*gi] == '0);
  end

  assign cur_nib   = act_nib[idx_reg];
  assign frame_end = (state_reg == DRIVE) && (idx_reg == LAST_IDX) && (cnt_reg == DRIVE_LAST);

  dec7seg u_dec7seg (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= BLANK;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      an_n_reg  <= '1;
      seg_reg   <= SEG_BLANK;
      dp_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      an_n_reg  <= an_n_next;
      seg_reg   <= seg_next;
      dp_n_reg  <= dp_n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg + 1'b1;
    case (state_reg)
      BLANK: begin
        if (GUARD == 0 || cnt_reg == GUARD_LAST) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end
      end
      DRIVE: begin
        if (cnt_reg == DRIVE_LAST) begin
          cnt_next   = '0;
          idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          state_next = (GUARD == 0) ? DRIVE : BLANK;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  // Outputs follow the current state one cycle later, so phase lengths are preserved
  always_comb begin
    an_n_next = '1;
    seg_next  = SEG_BLANK;
    dp_n_next = 1'b1;
    if (state_reg == DRIVE) begin
      an_n_next = ~(NUM_DIGITS'(1) << idx_reg);
      dp_n_next = ~act_dp_reg[idx_reg];
      seg_next  = (lz_en && (idx_reg != '0) && zero_above[idx_reg]) ? SEG_BLANK : dec_seg;
    end
  end

  // Pending data only moves to the display at the end of the last digit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_reg        <= 1'b0;
      pend_digits_reg <= '0;
      pend_dp_reg     <= '0;
      act_digits_reg  <= '0;
      act_dp_reg      <= '0;
    end else if (frame_end && pend_reg) begin
      act_digits_reg <= pend_digits_reg;
      act_dp_reg     <= pend_dp_reg;
      pend_reg       <= 1'b0;
    end else if (wr_valid && !pend_reg) begin
      pend_digits_reg <= wr_digits;
      pend_dp_reg     <= wr_dp;
      pend_reg        <= 1'b1;
    end
  end

  assign wr_ready = ~pend_reg;
  assign an_n     = an_n_reg;
  assign seg      = seg_reg;
  assign dp_n     = dp_n_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Cycle-by-cycle comparison of seg_scan_ctrl against a frame-arithmetic model.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int G     = 1;
  localparam int SLOT  = G + RD;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_digits = '0;
  logic [3:0]  wr_dp = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  an_n;
  logic [6:0]  seg;
  logic        dp_n;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic [3:0] m_act [ND];
  logic       m_act_dp [ND];
  logic [3:0] m_pdig [ND];
  logic       m_pdp [ND];
  logic       m_pend = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_digits (wr_digits),
    .wr_dp     (wr_dp),
    .lz_en     (lz_en),
    .an_n      (an_n),
    .seg       (seg),
    .dp_n      (dp_n)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, k);
    end
  endtask

  // One clock: expected outputs come from the phase within the frame and model data
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       supp;
    int         r, d;
    @(posedge clk);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (!rst_n) begin
      k = 0;
      m_pend = 1'b0;
      for (int j = 0; j < ND; j++) begin
        m_act[j] = '0; m_act_dp[j] = 1'b0; m_pdig[j] = '0; m_pdp[j] = 1'b0;
      end
    end else begin
      k++;
      r = (k - 1) % FRAME;
      d = r / SLOT;
      if ((r % SLOT) >= G) begin
        e_an = ~(4'b0001 << d);
        e_dp = ~m_act_dp[d];
        supp = lz_en && (d > 0);
        for (int j = d; j < ND; j++) if (m_act[j] != 4'd0) supp = 1'b0;
        e_seg = supp ? 7'h7F : seg_tbl[m_act[d]];
      end
      if (r == FRAME - 1 && m_pend) begin
        for (int j = 0; j < ND; j++) begin
          m_act[j] = m_pdig[j]; m_act_dp[j] = m_pdp[j];
        end
        m_pend = 1'b0;
      end else if (wr_valid && !m_pend) begin
        for (int j = 0; j < ND; j++) begin
          m_pdig[j] = wr_digits[4*j +: 4]; m_pdp[j] = wr_dp[j];
        end
        m_pend = 1'b1;
      end
    end
    #1;
    check("an_n", 16'(an_n), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp_n", 16'(dp_n), 16'(e_dp));
    check("wr_ready", 16'(wr_ready), 16'(!m_pend));
    $display("cycle %0d rst_n=%0b an_n=%b seg=%h dp_n=%0b wr_ready=%0b", k, rst_n, an_n, seg, dp_n, wr_ready);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp);
    wr_digits = d;
    wr_dp     = dp;
    wr_valid  = 1'b1;
    step();
    wr_valid  = 1'b0;
  endtask

  // Advance until the next edge sees the given pre-edge frame phase (bounded)
  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != ph; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(4);

    lz_en = 1'b0;
    write(16'h4321, 4'b0010);
    run(2 * FRAME + 5);

    write(16'h1111, 4'b0000);
    run(6);
    wr_digits = 16'h3333;
    wr_valid  = 1'b1;
    run(3);
    wr_valid  = 1'b0;
    run_to_phase(1);
    write(16'h2222, 4'b0101);
    run(2 * FRAME);

    run_to_phase(FRAME - 1);
    write(16'h5678, 4'b1000);
    run(2 * FRAME + 3);

    lz_en = 1'b1;
    write(16'h0050, 4'b0000);
    run(2 * FRAME + 2);
    write(16'h0000, 4'b0001);
    run(2 * FRAME + 2);
    write(16'h0C07, 4'b0000);
    run(2 * FRAME + 2);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] dv;
      for (int j = 0; j < ND; j++)
        dv[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      wr_digits = dv;
      wr_dp     = 4'($urandom);
      wr_valid  = ($urandom_range(0, 7) == 0);
      lz_en     = 1'($urandom);
      step();
    end
    wr_valid = 1'b0;
    lz_en    = 1'b0;

    run_to_phase(0);
    write(16'h9876, 4'b1111);
    run_to_phase(12);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(2 * FRAME + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
